// File: rtl/main_memory_controller_pkg.sv
// Shared configuration for the main memory backing store: geometry, latency and FSM encoding.
package main_memory_config;

    parameter int MAIN_MEMORY_ADDRESS_WIDTH = 32;
    parameter int MAIN_MEMORY_DATA_WIDTH    = 128;
    parameter int MAIN_MEMORY_NUM_BLOCKS    = 8;
    parameter int MAIN_MEMORY_BLOCK_SIZE    = 4;
    parameter int MAIN_MEMORY_LATENCY       = 4;

    parameter int MAIN_MEMORY_INDEX_LSB   = $clog2(MAIN_MEMORY_BLOCK_SIZE);
    parameter int MAIN_MEMORY_INDEX_WIDTH = $clog2(MAIN_MEMORY_NUM_BLOCKS);

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_BUSY = 2'd1,
        MM_RESP = 2'd2
    } mm_state_t;

endpackage

// File: rtl/main_memory_array.sv
// Block storage for main memory: synchronous write, registered read, cleared by synchronous reset.
module main_memory_array #(
    parameter int DATA_W     = 128,
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [NUM_BLOCKS];
    logic [DATA_W-1:0] r_rdata;

    // Storage and read register; an out-of-range read returns zero instead of the aliased block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= i_rzero ? '0 : r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_controller.sv
// Main memory controller: round-robin arbitration over NUM_REQ requesters, fixed-latency
// access sequencing, range checking, and one-cycle ack with registered read data.
module main_memory_controller
    import main_memory_config::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MEM_LATENCY = MAIN_MEMORY_LATENCY,
    parameter int ADDR_W      = MAIN_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_W      = MAIN_MEMORY_DATA_WIDTH,
    parameter int NUM_BLOCKS  = MAIN_MEMORY_NUM_BLOCKS,
    parameter int BLOCK_SIZE  = MAIN_MEMORY_BLOCK_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy
);

    localparam int IDX_LSB = $clog2(BLOCK_SIZE);
    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    mm_state_t          r_state;
    mm_state_t          w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_prio;
    logic [PTR_W-1:0]   r_gnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;

    logic [PTR_W-1:0]   w_sel;
    logic               w_found;
    logic               w_access;
    logic [PTR_W-1:0]   w_next_prio;
    logic [ADDR_W-1:0]  w_addr_hi;
    logic               w_oor;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic               w_unused_offset;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first requester at or after the priority pointer, wrapping.
    always_comb begin
        w_sel   = r_prio;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[rr_index(r_prio, k)]) begin
                w_sel   = rr_index(r_prio, k);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and array strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        case (r_state)
            MM_IDLE: begin
                if (w_found) begin
                    w_next_state = MM_BUSY;
                end else begin
                    w_next_state = MM_IDLE;
                end
            end
            MM_BUSY: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = MM_RESP;
                end else begin
                    w_next_state = MM_BUSY;
                end
            end
            MM_RESP: begin
                w_next_state = MM_IDLE;
            end
            default: begin
                w_next_state = MM_IDLE;
            end
        endcase
    end

    assign w_next_prio = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + PTR_W'(1);

    // Grant latches, latency counter and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_prio  <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                MM_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_sel;
                        r_we    <= we[w_sel];
                        r_addr  <= addr[int'(w_sel)*ADDR_W +: ADDR_W];
                        r_wdata <= wdata[int'(w_sel)*DATA_W +: DATA_W];
                        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
                    end
                end
                MM_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                MM_RESP: begin
                    r_prio <= w_next_prio;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Any address bit above the index field means the access misses the array.
    assign w_addr_hi       = r_addr >> (IDX_LSB + IDX_W);
    assign w_oor           = |w_addr_hi;
    assign w_idx           = r_addr[IDX_LSB +: IDX_W];
    assign w_unused_offset = ^r_addr[IDX_LSB-1:0];

    main_memory_array #(
        .DATA_W     (DATA_W),
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_access && r_we && !w_oor),
        .i_re    (w_access && !r_we),
        .i_rzero (w_oor),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (rdata)
    );

    assign w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt;
    assign ack          = (r_state == MM_RESP) ? w_gnt_onehot : '0;
    assign err          = (r_state == MM_RESP) && w_oor;
    assign busy         = (r_state != MM_IDLE);

endmodule

// File: tb/tb_main_memory_controller.sv
// Scoreboard bench for main_memory_controller: directed requests push expected acks, a monitor checks them.
module tb_main_memory_controller;

    localparam int LAT     = 4;
    localparam int ACK_LAT = LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [63:0]  addr;
    logic [255:0] wdata;
    logic [1:0]   ack;
    logic [127:0] rdata;
    logic         err;
    logic         busy;

    typedef struct {
        int           id;
        bit           is_read;
        logic [127:0] rd;
        logic         er;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    main_memory_controller dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic w, input logic [31:0] a, input logic [127:0] d,
                         input logic exp_err, input logic [127:0] exp_rd, input int lat);
        exp_t e;
        e.id      = id;
        e.is_read = !w;
        e.rd      = exp_rd;
        e.er      = exp_err;
        e.cyc     = cyc + lat;
        sb.push_back(e);
        req[id]               = 1'b1;
        we[id]                = w;
        addr[id*32 +: 32]     = a;
        wdata[id*128 +: 128]  = d;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 100; n++) begin
            if (req == 2'b00) break;
            @(negedge clk);
            #1;
        end
        check("req_drained", 128'(req), 128'd0);
    endtask

    task automatic do_reset();
        sync();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ack", 128'(ack), 128'd0);
    endtask

    // Requesters drop req in the cycle their ack arrives.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i]) req[i] = 1'b0;
        end
    end

    // Monitor: every ack is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b expected no ack (cycle %0d)", ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ack_mask", 128'(ack), 128'(2'b01 << mon_e.id));
                check("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
                check("err", 128'(err), 128'(mon_e.er));
                if (mon_e.is_read) check("rdata", rdata, mon_e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 128'(ack), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_rdata", rdata, 128'd0);
        check("reset_err", 128'(err), 128'd0);
        sync(); issue(0, 1'b0, 32'h0, 128'h0, 1'b0, 128'h0, ACK_LAT); wait_done();

        // Write then read back
        sync(); issue(0, 1'b1, 32'h8, 128'hDEAD_BEEF, 1'b0, 128'h0, ACK_LAT); wait_done();
        sync(); issue(0, 1'b0, 32'h8, 128'h0, 1'b0, 128'hDEAD_BEEF, ACK_LAT); wait_done();

        // Contention: req0 wins first, then a re-raised req0 must yield to the waiting req1
        do_reset();
        sync();
        issue(0, 1'b1, 32'h0, 128'hA5A5, 1'b0, 128'h0, ACK_LAT);
        issue(1, 1'b1, 32'h4, 128'h5A5A, 1'b0, 128'h0, 2*LAT + 3);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (req[0] == 1'b0) break;
        end
        check("req0_released", 128'(req[0]), 128'd0);
        issue(0, 1'b0, 32'h4, 128'h0, 1'b0, 128'h5A5A, 2*LAT + 4);
        wait_done();
        sync(); issue(1, 1'b0, 32'h0, 128'h0, 1'b0, 128'hA5A5, ACK_LAT); wait_done();

        // Out of range
        do_reset();
        sync(); issue(0, 1'b1, 32'h20, 128'h1234, 1'b1, 128'h0, ACK_LAT); wait_done();
        sync(); issue(0, 1'b0, 32'h0, 128'h0, 1'b0, 128'h0, ACK_LAT); wait_done();
        sync(); issue(1, 1'b1, 32'h0, 128'h5555, 1'b0, 128'h0, ACK_LAT); wait_done();
        sync(); issue(0, 1'b0, 32'h20, 128'h0, 1'b1, 128'h0, ACK_LAT); wait_done();
        sync(); issue(1, 1'b0, 32'h0, 128'h0, 1'b0, 128'h5555, ACK_LAT); wait_done();

        // Reset mid-access, in BUSY with cnt=2
        sync();
        req[0]        = 1'b1;
        we[0]         = 1'b1;
        addr[31:0]    = 32'h4;
        wdata[127:0]  = 128'hCAFE;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy_after", 128'(busy), 128'd0);
        check("midrst_rdata", rdata, 128'd0);
        repeat (8) @(negedge clk);
        sync(); issue(0, 1'b0, 32'h4, 128'h0, 1'b0, 128'h0, ACK_LAT); wait_done();

        // Aliasing through ignored byte-offset bits
        sync(); issue(0, 1'b1, 32'h1C, 128'h1111_2222, 1'b0, 128'h0, ACK_LAT); wait_done();
        sync(); issue(1, 1'b1, 32'h1D, 128'h3333_4444, 1'b0, 128'h0, ACK_LAT); wait_done();
        sync(); issue(0, 1'b0, 32'h1C, 128'h0, 1'b0, 128'h3333_4444, ACK_LAT); wait_done();
        sync(); issue(1, 1'b0, 32'h1F, 128'h0, 1'b0, 128'h3333_4444, ACK_LAT); wait_done();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
